mainfsm: RTL

Moore control FSM for the multicycle ARM datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It also drives the unconditional datapath controls, and the raw write requests NextPC, RegW, MemW and Branch. Sits between the instruction decoder and condlogic: condlogic gates RegW/MemW with its registered condition result to form RegWrite, MemWrite and PCWrite.

---
 rtl/mainfsm.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mainfsm.sv
// Purpose : Moore control FSM sequencing the multicycle ARM datapath (fetch/decode/execute/mem/writeback).
// Latency : one state per clock; DP 4, LDR 5, STR 4, B 3, undefined 3 cycles including FETCH.
// Backpressure: none; the FSM free-runs and Op/Funct are only sampled in DECODE and MEMADR.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset (forces FETCH)
//   Op, Funct         Instr[27:26] and Instr[25:20] from the instruction register
//   IRWrite..ALUOp    unconditional datapath controls
//   NextPC/RegW/MemW/Branch  raw write requests, gated downstream by condlogic
//   State             current state code for debug
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
    } ctrl_t;

    state_t state_q;
    state_t state_nxt;
    ctrl_t  ctrl_q;

    // Only Funct[5] (I) and Funct[0] (L/S) steer sequencing.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // Moore output table. Anything not set stays 0, which also makes UNKNOWN
    // and the unreachable codes issue no writes.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.nextpc    = 1'b1;
            end
            DECODE: begin
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            MEMADR: begin
                c.alusrcb   = 2'b01;
            end
            MEMRD: begin
                c.adrsrc    = 1'b1;
            end
            MEMWB: begin
                c.resultsrc = 2'b01;
                c.regw      = 1'b1;
            end
            MEMWR: begin
                c.adrsrc    = 1'b1;
                c.memw      = 1'b1;
            end
            EXECUTER: begin
                c.aluop     = 1'b1;
            end
            EXECUTEI: begin
                c.alusrcb   = 2'b01;
                c.aluop     = 1'b1;
            end
            ALUWB: begin
                c.regw      = 1'b1;
            end
            BRANCH: begin
                c.alusrca   = 2'b10;
                c.alusrcb   = 2'b01;
                c.resultsrc = 2'b10;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = FETCH;
        case (state_q)
            FETCH:    state_nxt = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_nxt = MEMADR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = UNKNOWN;
                endcase
            end
            MEMADR:   state_nxt = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_nxt = MEMWB;
            EXECUTER: state_nxt = ALUWB;
            EXECUTEI: state_nxt = ALUWB;
            default:  state_nxt = FETCH;
        endcase
    end

    // Outputs are registered from the next state so they change in lockstep
    // with State; reset loads the FETCH controls without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_of(FETCH);
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= ctrl_of(state_nxt);
        end
    end

    assign IRWrite   = ctrl_q.irwrite;
    assign AdrSrc    = ctrl_q.adrsrc;
    assign ALUSrcA   = ctrl_q.alusrca;
    assign ALUSrcB   = ctrl_q.alusrcb;
    assign ResultSrc = ctrl_q.resultsrc;
    assign ALUOp     = ctrl_q.aluop;
    assign NextPC    = ctrl_q.nextpc;
    assign RegW      = ctrl_q.regw;
    assign MemW      = ctrl_q.memw;
    assign Branch    = ctrl_q.branch;
    assign State     = state_q;

endmodule
